regs_wb_arbiter: RTL and testbench

Writeback controller for the 32-entry register file: arbitrates between the ALU and the load/store unit (LSU) for the single register-file write port, and keeps a per-register pending-write scoreboard that the issue stage uses to stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file write port. It registers the winning write for one cycle before it drives the port.

---
 rtl/regs_wb_arbiter_if.sv | 50 +++++
 rtl/regs_wb_arbiter.sv | 95 +++++++++
 tb/tb_regs_wb_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regs_wb_arbiter_if.sv
// Writeback bus between the execute/memory sources, the issue stage and the
// register-file write port of regs_wb_arbiter.
interface regs_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int IDXW = 5
);
  localparam int NREG = 1 << IDXW;

  logic            alu_valid_in;
  logic [IDXW-1:0] alu_idx_in;
  logic [XLEN-1:0] alu_data_in;
  logic            alu_ready_out;

  logic            lsu_valid_in;
  logic [IDXW-1:0] lsu_idx_in;
  logic [XLEN-1:0] lsu_data_in;
  logic            lsu_ready_out;

  logic            issue_en_in;
  logic [IDXW-1:0] issue_rd_in;
  logic [IDXW-1:0] chk_rs1_in;
  logic [IDXW-1:0] chk_rs2_in;
  logic [IDXW-1:0] chk_rd_in;
  logic            hazard_out;

  logic            wr_en_out;
  logic [IDXW-1:0] wr_idx_out;
  logic [XLEN-1:0] wr_data_out;
  logic [NREG-1:0] busy_out;

  modport slave (
    input  alu_valid_in, alu_idx_in, alu_data_in,
    output alu_ready_out,
    input  lsu_valid_in, lsu_idx_in, lsu_data_in,
    output lsu_ready_out,
    input  issue_en_in, issue_rd_in, chk_rs1_in, chk_rs2_in, chk_rd_in,
    output hazard_out,
    output wr_en_out, wr_idx_out, wr_data_out, busy_out
  );

  modport master (
    output alu_valid_in, alu_idx_in, alu_data_in,
    input  alu_ready_out,
    output lsu_valid_in, lsu_idx_in, lsu_data_in,
    input  lsu_ready_out,
    output issue_en_in, issue_rd_in, chk_rs1_in, chk_rs2_in, chk_rd_in,
    input  hazard_out,
    input  wr_en_out, wr_idx_out, wr_data_out, busy_out
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Register-file writeback arbiter (ALU vs LSU) with a pending-write scoreboard.
// Optional feature: define WB_ARB_ROUND_ROBIN_EN for round-robin contests; default is LSU priority.
module regs_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int IDXW = 5
) (
  input logic               clkin,
  input logic               rst_in,
  regs_wb_arbiter_if.slave  bus
);
  localparam int NREG = 1 << IDXW;
  typedef logic [IDXW-1:0] idx_t;

  logic            contest_p0;
  logic            pick_alu_p0;
  logic            alu_rdy_p0;
  logic            lsu_rdy_p0;
  logic            grant_p0;
  idx_t            g_idx_p0;
  logic [XLEN-1:0] g_data_p0;
  logic [NREG-1:0] busy_nxt_p0;

  logic            wr_en_p1;
  idx_t            wr_idx_p1;
  logic [XLEN-1:0] wr_data_p1;
  logic [NREG-1:0] busy_p1;

  // A nonzero index stalls if a write to it is pending or still sitting in the output register.
  function automatic logic idx_hit(input idx_t idx, input logic [NREG-1:0] busy,
                                   input logic wen, input idx_t widx);
    return (idx != '0) && (busy[idx] || (wen && (widx == idx)));
  endfunction

  assign contest_p0 = bus.alu_valid_in & bus.lsu_valid_in;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic rr_alu_p1;

  // The pointer names the source preferred in the next contest; it flips only when contested.
  always_ff @(posedge clkin) begin
    if (rst_in)          rr_alu_p1 <= 1'b1;
    else if (contest_p0) rr_alu_p1 <= ~rr_alu_p1;
  end

  assign pick_alu_p0 = rr_alu_p1;
`else
  assign pick_alu_p0 = 1'b0;
`endif

  // ---- stage p0: combinational arbitration and scoreboard update ----
  always_comb begin
    alu_rdy_p0 = bus.alu_valid_in & (~bus.lsu_valid_in | pick_alu_p0);
    lsu_rdy_p0 = bus.lsu_valid_in & (~bus.alu_valid_in | ~pick_alu_p0);
    grant_p0   = alu_rdy_p0 | lsu_rdy_p0;
    g_idx_p0   = alu_rdy_p0 ? bus.alu_idx_in  : bus.lsu_idx_in;
    g_data_p0  = alu_rdy_p0 ? bus.alu_data_in : bus.lsu_data_in;
  end

  always_comb begin
    busy_nxt_p0 = busy_p1;
    if (grant_p0 && (g_idx_p0 != '0))
      busy_nxt_p0[g_idx_p0] = 1'b0;
    // Applied after the clear so a same-cycle reissue keeps the register pending.
    if (bus.issue_en_in && (bus.issue_rd_in != '0))
      busy_nxt_p0[bus.issue_rd_in] = 1'b1;
    busy_nxt_p0[0] = 1'b0;
  end

  // ---- stage p1: registered write port and scoreboard ----
  always_ff @(posedge clkin) begin
    if (rst_in) begin
      wr_en_p1   <= 1'b0;
      wr_idx_p1  <= '0;
      wr_data_p1 <= '0;
      busy_p1    <= '0;
    end else begin
      wr_en_p1 <= grant_p0 && (g_idx_p0 != '0);
      if (grant_p0) begin
        wr_idx_p1  <= g_idx_p0;
        wr_data_p1 <= g_data_p0;
      end
      busy_p1 <= busy_nxt_p0;
    end
  end

  assign bus.alu_ready_out = alu_rdy_p0;
  assign bus.lsu_ready_out = lsu_rdy_p0;
  assign bus.wr_en_out     = wr_en_p1;
  assign bus.wr_idx_out    = wr_idx_p1;
  assign bus.wr_data_out   = wr_data_p1;
  assign bus.busy_out      = busy_p1;
  assign bus.hazard_out    = idx_hit(bus.chk_rs1_in, busy_p1, wr_en_p1, wr_idx_p1) |
                             idx_hit(bus.chk_rs2_in, busy_p1, wr_en_p1, wr_idx_p1) |
                             idx_hit(bus.chk_rd_in,  busy_p1, wr_en_p1, wr_idx_p1);
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: a write-port scoreboard plus direct
// checks on ready, hazard and busy state.
module tb_regs_wb_arbiter;
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];

  regs_wb_arbiter_if #(.XLEN(32), .IDXW(5)) bus ();

  regs_wb_arbiter #(.XLEN(32), .IDXW(5)) dut (
    .clkin  (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every registered write must match the next expected grant, in order.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.wr_en_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected actual idx=%0d data=%h required=no write",
                 bus.wr_idx_out, bus.wr_data_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.wr_idx_out !== e.idx || bus.wr_data_out !== e.data) begin
          errors++;
          $display("FAIL wr_port actual idx=%0d data=%h required idx=%0d data=%h",
                   bus.wr_idx_out, bus.wr_data_out, e.idx, e.data);
        end
      end
    end
  end

  initial begin
    bus.alu_valid_in = 1'b0; bus.alu_idx_in = '0; bus.alu_data_in = '0;
    bus.lsu_valid_in = 1'b0; bus.lsu_idx_in = '0; bus.lsu_data_in = '0;
    bus.issue_en_in  = 1'b0; bus.issue_rd_in = '0;
    bus.chk_rs1_in   = '0;   bus.chk_rs2_in  = '0; bus.chk_rd_in = '0;

    // Reset state
    step(); step(); #3;
    chk("rst_wr_en",   bus.wr_en_out,   0);
    chk("rst_wr_idx",  bus.wr_idx_out,  0);
    chk("rst_wr_data", bus.wr_data_out, 0);
    chk("rst_busy",    bus.busy_out,    0);
    chk("rst_hazard",  bus.hazard_out,  0);
    step(); rst = 1'b0;

    // Single ALU write clearing busy[5]
    bus.issue_en_in = 1'b1; bus.issue_rd_in = 5;
    step();
    bus.issue_en_in = 1'b0;
    bus.alu_valid_in = 1'b1; bus.alu_idx_in = 5; bus.alu_data_in = 32'hDEADBEEF;
    #3;
    chk("busy5_set",     bus.busy_out, 64'h20);
    chk("alu_ready_one", bus.alu_ready_out, 1);
    chk("lsu_ready_one", bus.lsu_ready_out, 0);
    exp_q.push_back('{idx: 5'd5, data: 32'hDEADBEEF});
    step();
    bus.alu_valid_in = 1'b0;
    #3;
    chk("busy5_clear", bus.busy_out, 0);

    // Contest: ALU idx 3 vs LSU idx 4
    step();
    bus.alu_valid_in = 1'b1; bus.alu_idx_in = 3; bus.alu_data_in = 32'h33333333;
    bus.lsu_valid_in = 1'b1; bus.lsu_idx_in = 4; bus.lsu_data_in = 32'h44444444;
    #3;
`ifdef WB_ARB_ROUND_ROBIN_EN
    chk("c1_alu_ready", bus.alu_ready_out, 1);
    chk("c1_lsu_ready", bus.lsu_ready_out, 0);
    exp_q.push_back('{idx: 5'd3, data: 32'h33333333});
    step();
    bus.alu_valid_in = 1'b0;
    #3;
    chk("c1b_lsu_ready", bus.lsu_ready_out, 1);
    chk("c1b_alu_ready", bus.alu_ready_out, 0);
    exp_q.push_back('{idx: 5'd4, data: 32'h44444444});
    step();
    bus.lsu_valid_in = 1'b0;
`else
    chk("c1_lsu_ready", bus.lsu_ready_out, 1);
    chk("c1_alu_ready", bus.alu_ready_out, 0);
    exp_q.push_back('{idx: 5'd4, data: 32'h44444444});
    step();
    bus.lsu_valid_in = 1'b0;
    #3;
    chk("c1b_alu_ready", bus.alu_ready_out, 1);
    chk("c1b_lsu_ready", bus.lsu_ready_out, 0);
    exp_q.push_back('{idx: 5'd3, data: 32'h33333333});
    step();
    bus.alu_valid_in = 1'b0;
`endif

    // Second contest: LSU wins in both modes (ALU won the previous round-robin contest)
    bus.alu_valid_in = 1'b1; bus.alu_idx_in = 10; bus.alu_data_in = 32'hAAAA000A;
    bus.lsu_valid_in = 1'b1; bus.lsu_idx_in = 11; bus.lsu_data_in = 32'hBBBB000B;
    #3;
    chk("c2_lsu_ready", bus.lsu_ready_out, 1);
    chk("c2_alu_ready", bus.alu_ready_out, 0);
    exp_q.push_back('{idx: 5'd11, data: 32'hBBBB000B});
    step();
    bus.lsu_valid_in = 1'b0;
    #3;
    chk("c2b_alu_ready", bus.alu_ready_out, 1);
    exp_q.push_back('{idx: 5'd10, data: 32'hAAAA000A});
    step();
    bus.alu_valid_in = 1'b0;

    // Scoreboard hazard window on x7
    bus.issue_en_in = 1'b1; bus.issue_rd_in = 7;
    step();
    bus.issue_en_in = 1'b0; bus.chk_rs1_in = 7;
    #3;
    chk("haz_busy7", bus.hazard_out, 1);
    step();
    bus.alu_valid_in = 1'b1; bus.alu_idx_in = 7; bus.alu_data_in = 32'h00000077;
    #3;
    chk("haz_grant7",  bus.hazard_out, 1);
    chk("alu_ready7",  bus.alu_ready_out, 1);
    exp_q.push_back('{idx: 5'd7, data: 32'h00000077});
    step();
    bus.alu_valid_in = 1'b0;
    #3;
    chk("busy7_clear",   bus.busy_out, 0);
    chk("haz_inflight7", bus.hazard_out, 1);
    step(); #3;
    chk("haz_done7", bus.hazard_out, 0);
    bus.chk_rs1_in = 0;

    // rs2 and rd operand paths
    bus.issue_en_in = 1'b1; bus.issue_rd_in = 12;
    step();
    bus.issue_en_in = 1'b0; bus.chk_rs2_in = 12;
    #3;
    chk("haz_rs2", bus.hazard_out, 1);
    step();
    bus.chk_rs2_in = 0; bus.chk_rd_in = 12;
    #3;
    chk("haz_rd", bus.hazard_out, 1);
    step();
    bus.chk_rd_in = 13;
    #3;
    chk("haz_rd_clean", bus.hazard_out, 0);
    bus.chk_rd_in = 0;

    // Same-cycle set and clear on x9
    bus.issue_en_in = 1'b1; bus.issue_rd_in = 9;
    step();
    bus.lsu_valid_in = 1'b1; bus.lsu_idx_in = 9; bus.lsu_data_in = 32'h00000099;
    #3;
    chk("lsu_ready9", bus.lsu_ready_out, 1);
    exp_q.push_back('{idx: 5'd9, data: 32'h00000099});
    step();
    bus.issue_en_in = 1'b0; bus.lsu_valid_in = 1'b0;
    #3;
    chk("busy9_kept", bus.busy_out, 64'h1200);

    // x0 handling
    bus.alu_valid_in = 1'b1; bus.alu_idx_in = 0; bus.alu_data_in = 32'h00001234;
    #3;
    chk("alu_ready_x0", bus.alu_ready_out, 1);
    step();
    bus.alu_valid_in = 1'b0;
    bus.issue_en_in = 1'b1; bus.issue_rd_in = 0;
    #3;
    chk("x0_wr_en",   bus.wr_en_out,   0);
    chk("x0_wr_idx",  bus.wr_idx_out,  0);
    chk("x0_wr_data", bus.wr_data_out, 32'h00001234);
    step();
    bus.issue_en_in = 1'b0;
    #3;
    chk("x0_busy_same", bus.busy_out, 64'h1200);
    chk("x0_hazard",    bus.hazard_out, 0);
    chk("hold_wr_data", bus.wr_data_out, 32'h00001234);

    // Reset mid-operation
    for (int i = 1; i < 32; i++) begin
      bus.issue_en_in = 1'b1; bus.issue_rd_in = 5'(i);
      step();
    end
    bus.issue_en_in = 1'b0;
    #3;
    chk("busy_all", bus.busy_out, 64'hFFFFFFFE);
    bus.alu_valid_in = 1'b1; bus.alu_idx_in = 2; bus.alu_data_in = 32'h000000AB;
    rst = 1'b1;
    #1;
    chk("rst_ready_kept", bus.alu_ready_out, 1);
    step();
    rst = 1'b0; bus.alu_valid_in = 1'b0;
    #3;
    chk("mid_rst_busy",    bus.busy_out,    0);
    chk("mid_rst_wr_en",   bus.wr_en_out,   0);
    chk("mid_rst_wr_idx",  bus.wr_idx_out,  0);
    chk("mid_rst_wr_data", bus.wr_data_out, 0);

    step(); step(); #3;
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
